macc_hs: RTL
============

# macc_hs

Parametrised memory-access stage sitting between EXU and write-back. It extends the single-cycle access stage with a request/grant/rvalid handshake to data memory, so memory can take multiple cycles. It also adds internal byte-lane alignment for stores, load extraction with sign or zero extension, and misalignment detection. Data width is selectable between 32 and 64 bits.

## Interface
- XLEN, 32, data/address width; legal values 32, 64
- clk_sys  in  1  clock
- rst_sys  in  1  reset; synchronous, active-high
- i_valid  in  1  EXU presents an instruction
- o_ready  out  1  stage accepts (high only in IDLE)
- i_rd_wen  in  1  instruction writes rd
- i_rd_addr  in  5  destination register
- i_mem_rreq / i_mem_wreq  in  1 each  load / store
- i_mem_size  in  2  0=B, 1=H, 2=W, 3=D
- i_mem_unsigned  in  1  zero-extend load
- i_mem_addr  in  XLEN  byte address
- i_mem_wdata  in  XLEN  store data, LSB-justified
- i_alu_result  in  XLEN  non-memory result
- o_mem_req  out  1  memory request
- i_mem_gnt  in  1  request accepted
- o_mem_we  out  1  write
- o_mem_be  out  XLEN/8  byte enables
- o_mem_addr  out  XLEN  address, low log2(XLEN/8) bits cleared
- o_mem_wdata  out  XLEN  lane-shifted store data
- i_mem_rvalid  in  1  read data valid
- i_mem_rdata  in  XLEN  read data
- o_wb_valid  out  1  one-cycle result pulse
- o_rd_wen  out  1  write-back enable
- o_rd_addr  out  5  write-back register
- o_rd_data  out  XLEN  load data / ALU result / faulting address
- o_exc_misalign  out  1  misaligned or illegal-size access

## Operation
- States:
  - IDLE: accept when i_valid.
  - REQ: o_mem_req high, held until i_mem_gnt.
  - WAIT: load awaiting i_mem_rvalid.
- Acceptance in IDLE:
  - Non-memory instruction: latch i_alu_result into o_rd_data and stay in IDLE.
  - Aligned memory instruction: register the memory outputs and go to REQ.
  - Misaligned memory instruction: no request is issued. o_rd_data = i_mem_addr, o_exc_misalign=1, o_rd_wen=0; stay in IDLE.
- Alignment rule: offset = addr mod XLEN/8. An access is misaligned when offset is not a multiple of 2^size. Size D with XLEN=32 is always flagged.
- REQ, on i_mem_gnt:
  - Store: pulse o_wb_valid next cycle with o_rd_wen=0; go to IDLE.
  - Load: go to WAIT.
- WAIT, on i_mem_rvalid: compute (rdata >> 8*offset), truncate to size, extend by i_mem_unsigned. Register the result into o_rd_data, pulse o_wb_valid, go to IDLE.
- Store encoding: be = ((1<<2^size)-1) << offset; wdata = i_mem_wdata << 8*offset.
- i_mem_rreq and i_mem_wreq both set: treated as a load; the write is suppressed.
- i_mem_rvalid is ignored outside WAIT. i_mem_gnt is ignored outside REQ.
- o_mem_addr, o_mem_be, o_mem_we and o_mem_wdata are stable from REQ entry until grant.

## Timing
- Reset values: state IDLE, o_ready=1. o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata, o_wb_valid, o_rd_wen, o_rd_addr, o_rd_data and o_exc_misalign all 0.
- Latencies (instruction accepted in cycle N):
  - Non-memory or misaligned: o_wb_valid in N+1. Back-to-back acceptance gives one result per cycle.
  - Memory: o_mem_req from N+1. Grant in cycle G:
    - Store: o_wb_valid in G+1.
    - Load with rvalid in cycle R (R ≥ G+1): o_wb_valid in R+1.
- The cycle in which o_wb_valid rises is already IDLE, so a new instruction is accepted in that cycle.
- Reset mid-operation returns to IDLE next cycle and drops o_mem_req. A late i_mem_rvalid after reset produces no o_wb_valid.

## Structure
- macc_pkg:
  - size encodings SZ_B, SZ_H, SZ_W, SZ_D
  - state enum ST_IDLE, ST_REQ, ST_WAIT
  - function for the byte-lane mask
- Sub-module macc_lane_align (combinational): computes be, shifted wdata, misalign flag and load extraction/extension. Instantiated once in macc_hs.
- Registers use the codebase's DFF_RST primitive with reset wired to rst_sys.

## Test plan
- ALU op, alu=0x12345678, rd=5 → next cycle o_wb_valid, o_rd_data=0x12345678, o_rd_addr=5, o_mem_req never high.
- SB addr 0x1003, wdata 0xAB, gnt after 2 cycles → o_mem_addr 0x1000, be 4'b1000, wdata 0xAB000000, held until gnt. o_wb_valid one cycle after gnt with rd_wen=0.
- LH addr 0x2002, rdata 0x80010000 returned 3 cycles after gnt → o_rd_data 0xFFFF8001. Same with i_mem_unsigned=1 → 0x00008001.
- LW addr 0x1002 → no request; next cycle o_wb_valid, o_exc_misalign=1, o_rd_data=0x1002, o_rd_wen=0. Repeat LD with XLEN=32 → same flag. With XLEN=64, LD addr 0x1008 → be 8'hFF.
- rst_sys asserted during WAIT, then i_mem_rvalid pulsed → o_wb_valid stays 0, o_ready=1 the cycle after reset.
- Three ALU ops on consecutive cycles, then a load, then an ALU op → three consecutive o_wb_valid pulses. The ALU op is stalled (o_ready=0) until the load's o_wb_valid cycle, then accepted in that cycle.

Source files
------------

// File: rtl/macc_pkg.sv
// Shared encodings for the memory-access stage: access sizes, FSM states
// and the byte-lane mask helper used for store enables.
package macc_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // Enables for a 2^size-byte access starting at byte lane 'offset'.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] offset);
    logic [7:0] base;
    base = 8'h00;
    case (size)
      SZ_B: base = 8'h01;
      SZ_H: base = 8'h03;
      SZ_W: base = 8'h0F;
      SZ_D: base = 8'hFF;
    endcase
    return base << offset;
  endfunction

endpackage

// File: rtl/DFF_RST.sv
// Generic register with synchronous active-high reset to zero.
module DFF_RST #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/macc_lane_align.sv
// Combinational byte-lane logic: store enables and shifted data, misalignment
// detection, and load extraction with sign or zero extension.
module macc_lane_align
  import macc_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int NB   = XLEN / 8,
  localparam int OFFW = $clog2(NB)
) (
  input  logic [1:0]      size,
  input  logic [OFFW-1:0] offset,
  input  logic            uns,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [NB-1:0]   be,
  output logic [XLEN-1:0] wdata_sh,
  output logic            misalign,
  output logic [XLEN-1:0] load_data
);

  logic [2:0]      off3;
  logic [5:0]      bit_sh;
  logic [XLEN-1:0] rsh;
  logic [XLEN-1:0] keep;
  logic            sign;

  always_comb begin
    off3     = 3'(offset);
    bit_sh   = {off3, 3'b000};
    be       = NB'(lane_mask(size, off3));
    wdata_sh = wdata << bit_sh;
    // A doubleword can never fit a 32-bit bus; otherwise offset must be size-aligned.
    misalign = ((XLEN == 32) && (size == SZ_D)) ||
               ((off3 & ((3'd1 << size) - 3'd1)) != 3'd0);

    rsh  = rdata >> bit_sh;
    keep = '1;
    sign = 1'b0;
    case (size)
      SZ_B: begin keep = XLEN'(64'hFF);        sign = rsh[7];  end
      SZ_H: begin keep = XLEN'(64'hFFFF);      sign = rsh[15]; end
      SZ_W: begin keep = XLEN'(64'hFFFF_FFFF); sign = rsh[31]; end
      SZ_D: begin keep = '1;                   sign = 1'b0;    end
    endcase
    load_data = (rsh & keep) | ({XLEN{sign & ~uns}} & ~keep);
  end

endmodule

// File: rtl/macc_hs.sv
// Memory-access stage between EXU and write-back with a req/gnt/rvalid
// handshake to data memory, store lane alignment and load extension.
module macc_hs
  import macc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk_sys,
  input  logic              rst_sys,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_rd_wen,
  input  logic [4:0]        i_rd_addr,
  input  logic              i_mem_rreq,
  input  logic              i_mem_wreq,
  input  logic [1:0]        i_mem_size,
  input  logic              i_mem_unsigned,
  input  logic [XLEN-1:0]   i_mem_addr,
  input  logic [XLEN-1:0]   i_mem_wdata,
  input  logic [XLEN-1:0]   i_alu_result,
  output logic              o_mem_req,
  input  logic              i_mem_gnt,
  output logic              o_mem_we,
  output logic [XLEN/8-1:0] o_mem_be,
  output logic [XLEN-1:0]   o_mem_addr,
  output logic [XLEN-1:0]   o_mem_wdata,
  input  logic              i_mem_rvalid,
  input  logic [XLEN-1:0]   i_mem_rdata,
  output logic              o_wb_valid,
  output logic              o_rd_wen,
  output logic [4:0]        o_rd_addr,
  output logic [XLEN-1:0]   o_rd_data,
  output logic              o_exc_misalign
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  state_e          state_d, state_q;
  logic [1:0]      state_raw;
  logic            mem_we_d, mem_we_q;
  logic [NB-1:0]   mem_be_d, mem_be_q;
  logic [XLEN-1:0] mem_addr_d, mem_addr_q;
  logic [XLEN-1:0] mem_wdata_d, mem_wdata_q;
  logic [1:0]      size_d, size_q;
  logic [OFFW-1:0] off_d, off_q;
  logic            uns_d, uns_q;
  logic            pend_wen_d, pend_wen_q;
  logic            wb_valid_d, wb_valid_q;
  logic            rd_wen_d, rd_wen_q;
  logic [4:0]      rd_addr_d, rd_addr_q;
  logic [XLEN-1:0] rd_data_d, rd_data_q;
  logic            exc_d, exc_q;

  logic            in_idle;
  logic            is_mem;
  logic [1:0]      la_size;
  logic [OFFW-1:0] la_off;
  logic [NB-1:0]   la_be;
  logic [XLEN-1:0] la_wdata;
  logic            la_mis;
  logic [XLEN-1:0] la_load;

  assign state_q = state_e'(state_raw);
  assign in_idle = (state_q == ST_IDLE);
  assign is_mem  = i_mem_rreq | i_mem_wreq;

  // Alignment logic sees the incoming op in IDLE and the latched op while waiting.
  assign la_size = in_idle ? i_mem_size : size_q;
  assign la_off  = in_idle ? i_mem_addr[OFFW-1:0] : off_q;

  macc_lane_align #(.XLEN(XLEN)) u_align (
    .size      (la_size),
    .offset    (la_off),
    .uns       (uns_q),
    .wdata     (i_mem_wdata),
    .rdata     (i_mem_rdata),
    .be        (la_be),
    .wdata_sh  (la_wdata),
    .misalign  (la_mis),
    .load_data (la_load)
  );

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    size_d      = size_q;
    off_d       = off_q;
    uns_d       = uns_q;
    pend_wen_d  = pend_wen_q;
    wb_valid_d  = 1'b0;
    rd_wen_d    = rd_wen_q;
    rd_addr_d   = rd_addr_q;
    rd_data_d   = rd_data_q;
    exc_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          rd_addr_d = i_rd_addr;
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            rd_wen_d   = i_rd_wen;
            rd_data_d  = i_alu_result;
          end else if (la_mis) begin
            wb_valid_d = 1'b1;
            rd_wen_d   = 1'b0;
            rd_data_d  = i_mem_addr;
            exc_d      = 1'b1;
          end else begin
            // A simultaneous read and write request is handled as a plain load.
            mem_we_d    = i_mem_wreq & ~i_mem_rreq;
            mem_be_d    = la_be;
            mem_addr_d  = {i_mem_addr[XLEN-1:OFFW], OFFW'(0)};
            mem_wdata_d = la_wdata;
            size_d      = i_mem_size;
            off_d       = i_mem_addr[OFFW-1:0];
            uns_d       = i_mem_unsigned;
            pend_wen_d  = i_rd_wen;
            state_d     = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (i_mem_gnt) begin
          if (mem_we_q) begin
            wb_valid_d = 1'b1;
            rd_wen_d   = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (i_mem_rvalid) begin
          wb_valid_d = 1'b1;
          rd_wen_d   = pend_wen_q;
          rd_data_d  = la_load;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  DFF_RST #(.W(2))    u_state     (.clk(clk_sys), .rst(rst_sys), .d(state_d),     .q(state_raw));
  DFF_RST #(.W(1))    u_mem_we    (.clk(clk_sys), .rst(rst_sys), .d(mem_we_d),    .q(mem_we_q));
  DFF_RST #(.W(NB))   u_mem_be    (.clk(clk_sys), .rst(rst_sys), .d(mem_be_d),    .q(mem_be_q));
  DFF_RST #(.W(XLEN)) u_mem_addr  (.clk(clk_sys), .rst(rst_sys), .d(mem_addr_d),  .q(mem_addr_q));
  DFF_RST #(.W(XLEN)) u_mem_wdata (.clk(clk_sys), .rst(rst_sys), .d(mem_wdata_d), .q(mem_wdata_q));
  DFF_RST #(.W(2))    u_size      (.clk(clk_sys), .rst(rst_sys), .d(size_d),      .q(size_q));
  DFF_RST #(.W(OFFW)) u_off       (.clk(clk_sys), .rst(rst_sys), .d(off_d),       .q(off_q));
  DFF_RST #(.W(1))    u_uns       (.clk(clk_sys), .rst(rst_sys), .d(uns_d),       .q(uns_q));
  DFF_RST #(.W(1))    u_pend_wen  (.clk(clk_sys), .rst(rst_sys), .d(pend_wen_d),  .q(pend_wen_q));
  DFF_RST #(.W(1))    u_wb_valid  (.clk(clk_sys), .rst(rst_sys), .d(wb_valid_d),  .q(wb_valid_q));
  DFF_RST #(.W(1))    u_rd_wen    (.clk(clk_sys), .rst(rst_sys), .d(rd_wen_d),    .q(rd_wen_q));
  DFF_RST #(.W(5))    u_rd_addr   (.clk(clk_sys), .rst(rst_sys), .d(rd_addr_d),   .q(rd_addr_q));
  DFF_RST #(.W(XLEN)) u_rd_data   (.clk(clk_sys), .rst(rst_sys), .d(rd_data_d),   .q(rd_data_q));
  DFF_RST #(.W(1))    u_exc       (.clk(clk_sys), .rst(rst_sys), .d(exc_d),       .q(exc_q));

  assign o_ready        = in_idle;
  assign o_mem_req      = (state_q == ST_REQ);
  assign o_mem_we       = mem_we_q;
  assign o_mem_be       = mem_be_q;
  assign o_mem_addr     = mem_addr_q;
  assign o_mem_wdata    = mem_wdata_q;
  assign o_wb_valid     = wb_valid_q;
  assign o_rd_wen       = rd_wen_q;
  assign o_rd_addr      = rd_addr_q;
  assign o_rd_data      = rd_data_q;
  assign o_exc_misalign = exc_q;

endmodule
